// File: rtl/i2c_poll_sequencer.sv
// Autonomous I2C sensor poller: walks enabled slots each round, drives i2c_master control, shadows results for Avalon reads.
// Optional interrupt output enabled by defining I2C_POLL_SEQUENCER_IRQ_EN.
module i2c_poll_sequencer #(
    parameter int NUM_SLOTS      = 4,
    parameter int DEFAULT_PERIOD = 500000,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic        read,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        i2c_ena,
    output logic [6:0]  i2c_addr,
    output logic        i2c_rw,
    output logic [31:0] i2c_data_wr,
    output logic [7:0]  i2c_number_of_bytes,
    output logic        i2c_read_only,
    input  logic        i2c_busy,
    input  logic        i2c_ack_error,
    input  logic [31:0] i2c_data_rd,
    input  logic [7:0]  i2c_byte_counter,
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
    output logic        irq,
`endif
    input  logic        i2c_fifo_write_ack
);

    typedef enum logic [2:0] {IDLE, WAIT_PERIOD, SELECT, START, XFER, DRAIN, STORE} state_t;

    localparam logic [31:0] TMO_LIMIT   = 32'(TIMEOUT_CYCLES);
    localparam logic [31:0] PERIOD_INIT = 32'(DEFAULT_PERIOD);
    localparam logic [3:0]  SLOT_MASK   = 4'((1 << NUM_SLOTS) - 1);

    state_t      state_q, state_d;
    logic        run_q, run_d, single_q, single_d;
    logic [31:0] period_q, period_d;
    logic        ack_err_q, ack_err_d, timeout_q, timeout_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [3:0]  slot_en_q, slot_en_d;
    logic [18:0] slot_cfg_q [4];
    logic [18:0] slot_cfg_d [4];
    logic [31:0] slot_data_q [4];
    logic [31:0] slot_data_d [4];
    logic [31:0] round_cnt_q, round_cnt_d;
    logic [2:0]  slot_q, slot_d;
    logic [31:0] period_cnt_q, period_cnt_d;
    logic [31:0] tmo_cnt_q, tmo_cnt_d;
    logic [31:0] hold_q, hold_d;
    logic        captured_q, captured_d, ack_seen_q, ack_seen_d;
    logic        tmo_hit_q, tmo_hit_d, xact_q, xact_d, fifo_ack_q;
    logic        ena_q, ena_d, rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  ptr_q, ptr_d;
    logic [2:0]  nbytes_q, nbytes_d;
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
    logic        irq_en_q, irq_en_d, round_done_q, round_done_d, irq_q, irq_d;
`endif

    logic        wr_ctrl, slot_ok, fifo_rise, err_inc;
    logic [1:0]  sidx;
    logic [2:0]  nb_raw;
    logic [31:0] period_load;
    logic        unused_read;

    assign unused_read = read;
    assign wr_ctrl     = write && (address == 4'd0);
    assign slot_ok     = int'(address[1:0]) < NUM_SLOTS;
    assign sidx        = slot_q[1:0];
    assign fifo_rise   = i2c_fifo_write_ack && !fifo_ack_q;
    assign period_load = (period_q == 32'd0) ? 32'd1 : period_q;

    always_comb begin
        // NOTE: every _d starts as its _q, so no path through this block can infer a latch.
        state_d      = state_q;
        run_d        = run_q;
        single_d     = single_q;
        period_d     = period_q;
        ack_err_d    = ack_err_q;
        timeout_d    = timeout_q;
        err_cnt_d    = err_cnt_q;
        slot_en_d    = slot_en_q;
        slot_cfg_d   = slot_cfg_q;
        slot_data_d  = slot_data_q;
        round_cnt_d  = round_cnt_q;
        slot_d       = slot_q;
        period_cnt_d = period_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        hold_d       = hold_q;
        captured_d   = captured_q;
        ack_seen_d   = ack_seen_q;
        tmo_hit_d    = tmo_hit_q;
        xact_d       = xact_q;
        ena_d        = ena_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        ptr_d        = ptr_q;
        nbytes_d     = nbytes_q;
        nb_raw       = slot_cfg_q[sidx][18:16];
        err_inc      = 1'b0;
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
        irq_en_d     = irq_en_q;
        round_done_d = round_done_q;
        irq_d        = irq_en_q && (round_done_q || ack_err_q || timeout_q);
`endif

        // Software writes come first so hardware sets below win a same-cycle race.
        if (write) begin
            case (address)
                4'd0: begin
                    run_d    = writedata[0];
                    single_d = writedata[1];
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
                    irq_en_d = writedata[2];
`endif
                end
                4'd1: period_d = writedata;
                4'd2: begin
                    if (writedata[1])  ack_err_d = 1'b0;
                    if (writedata[2])  timeout_d = 1'b0;
                    if (writedata[16]) err_cnt_d = 8'd0;
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
                    if (writedata[3])  round_done_d = 1'b0;
`endif
                end
                4'd3: slot_en_d = writedata[3:0] & SLOT_MASK;
                4'd4, 4'd5, 4'd6, 4'd7:
                    if (slot_ok) slot_cfg_d[address[1:0]] = {writedata[18:8], 1'b0, writedata[6:0]};
                default: ;
            endcase
        end

        if (state_q != IDLE) period_cnt_d = (period_cnt_q != 32'd0) ? period_cnt_q - 32'd1 : 32'd0;

        case (state_q)
            IDLE: begin
                if (run_q || single_q) begin
                    period_cnt_d = period_load;
                    slot_d       = 3'd0;
                    xact_d       = 1'b0;
                    state_d      = SELECT;
                end
            end
            // period_cnt counts the cycles left in the round including this one.
            WAIT_PERIOD: begin
                if (!run_q) begin
                    state_d = IDLE;
                end else if (period_cnt_q <= 32'd1) begin
                    period_cnt_d = period_load;
                    slot_d       = 3'd0;
                    xact_d       = 1'b0;
                    state_d      = SELECT;
                end
            end
            SELECT: begin
                if (int'(slot_q) >= NUM_SLOTS) begin
                    if (xact_q) round_cnt_d = round_cnt_q + 32'd1;
                    single_d = wr_ctrl && writedata[1];
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
                    round_done_d = 1'b1;
`endif
                    state_d = run_q ? WAIT_PERIOD : IDLE;
                end else if (slot_en_q[sidx]) begin
                    state_d = START;
                end else begin
                    slot_d = slot_q + 3'd1;
                end
            end
            START: begin
                addr_d     = slot_cfg_q[sidx][6:0];
                ptr_d      = slot_cfg_q[sidx][15:8];
                nbytes_d   = (nb_raw == 3'd0) ? 3'd1 : (nb_raw > 3'd4) ? 3'd4 : nb_raw;
                rw_d       = 1'b1;
                ena_d      = 1'b1;
                tmo_cnt_d  = 32'd1;
                captured_d = 1'b0;
                ack_seen_d = 1'b0;
                tmo_hit_d  = 1'b0;
                xact_d     = 1'b1;
                state_d    = XFER;
            end
            XFER, DRAIN: begin
                tmo_cnt_d = tmo_cnt_q + 32'd1;
                if (fifo_rise) begin
                    hold_d     = i2c_data_rd;
                    captured_d = 1'b1;
                end
                if (tmo_cnt_q >= TMO_LIMIT) begin
                    ena_d     = 1'b0;
                    timeout_d = 1'b1;
                    err_inc   = 1'b1;
                    tmo_hit_d = 1'b1;
                    state_d   = STORE;
                end else if (state_q == XFER) begin
                    if (i2c_byte_counter >= {5'd0, nbytes_q}) begin
                        ena_d   = 1'b0;
                        state_d = DRAIN;
                    end
                end else if (!i2c_busy) begin
                    // The master holds its NACK flag once idle, so sample it here.
                    ack_seen_d = i2c_ack_error;
                    state_d    = STORE;
                end
            end
            STORE: begin
                if (!tmo_hit_q) begin
                    if (ack_seen_q) begin
                        ack_err_d = 1'b1;
                        err_inc   = 1'b1;
                    end else if (captured_q) begin
                        slot_data_d[sidx] = hold_q;
                    end
                end
                slot_d  = slot_q + 3'd1;
                state_d = SELECT;
            end
            default: state_d = IDLE;
        endcase

        if (err_inc && err_cnt_d != 8'hFF) err_cnt_d = err_cnt_d + 8'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            run_q        <= 1'b0;
            single_q     <= 1'b0;
            period_q     <= PERIOD_INIT;
            ack_err_q    <= 1'b0;
            timeout_q    <= 1'b0;
            err_cnt_q    <= 8'd0;
            slot_en_q    <= 4'd0;
            // NOTE: the slot tables are a handful of flops that software reads back, so they are reset like any register.
            for (int i = 0; i < 4; i++) begin
                slot_cfg_q[i]  <= '0;
                slot_data_q[i] <= '0;
            end
            round_cnt_q  <= 32'd0;
            slot_q       <= 3'd0;
            period_cnt_q <= 32'd0;
            tmo_cnt_q    <= 32'd0;
            hold_q       <= 32'd0;
            captured_q   <= 1'b0;
            ack_seen_q   <= 1'b0;
            tmo_hit_q    <= 1'b0;
            xact_q       <= 1'b0;
            fifo_ack_q   <= 1'b0;
            ena_q        <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= 7'd0;
            ptr_q        <= 8'd0;
            nbytes_q     <= 3'd0;
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
            irq_en_q     <= 1'b0;
            round_done_q <= 1'b0;
            irq_q        <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments only, so every flop samples the pre-edge value of the others.
            state_q      <= state_d;
            run_q        <= run_d;
            single_q     <= single_d;
            period_q     <= period_d;
            ack_err_q    <= ack_err_d;
            timeout_q    <= timeout_d;
            err_cnt_q    <= err_cnt_d;
            slot_en_q    <= slot_en_d;
            slot_cfg_q   <= slot_cfg_d;
            slot_data_q  <= slot_data_d;
            round_cnt_q  <= round_cnt_d;
            slot_q       <= slot_d;
            period_cnt_q <= period_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            hold_q       <= hold_d;
            captured_q   <= captured_d;
            ack_seen_q   <= ack_seen_d;
            tmo_hit_q    <= tmo_hit_d;
            xact_q       <= xact_d;
            fifo_ack_q   <= i2c_fifo_write_ack;
            ena_q        <= ena_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            ptr_q        <= ptr_d;
            nbytes_q     <= nbytes_d;
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
            irq_en_q     <= irq_en_d;
            round_done_q <= round_done_d;
            irq_q        <= irq_d;
`endif
        end
    end

    always_comb begin
        readdata = 32'hDEAD_BEEF;
        case (address)
            4'd0: begin
                readdata    = {30'd0, single_q, run_q};
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
                readdata[2] = irq_en_q;
`endif
            end
            4'd1: readdata = period_q;
            4'd2: begin
                readdata = {16'd0, err_cnt_q, 5'd0, timeout_q, ack_err_q, state_q != IDLE};
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
                readdata[3] = round_done_q;
`endif
            end
            4'd3: readdata = {28'd0, slot_en_q};
            4'd4, 4'd5, 4'd6, 4'd7: readdata = slot_ok ? {13'd0, slot_cfg_q[address[1:0]]} : 32'd0;
            4'd8, 4'd9, 4'd10, 4'd11: readdata = slot_ok ? slot_data_q[address[1:0]] : 32'd0;
            4'd12: readdata = round_cnt_q;
            default: ;
        endcase
    end

    assign waitrequest         = 1'b0;
    assign i2c_ena             = ena_q;
    assign i2c_addr            = addr_q;
    assign i2c_rw              = rw_q;
    assign i2c_data_wr         = {24'd0, ptr_q};
    assign i2c_number_of_bytes = {5'd0, nbytes_q};
    assign i2c_read_only       = 1'b0;
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
    assign irq                 = irq_q;
`endif

endmodule

// File: tb/tb_i2c_poll_sequencer.sv
// Self-checking bench for i2c_poll_sequencer: behavioural i2c_master model plus a transaction scoreboard.
module tb_i2c_poll_sequencer;

    localparam int TMO = 100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  address = '0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic        read = 1'b0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        i2c_ena;
    logic [6:0]  i2c_addr;
    logic        i2c_rw;
    logic [31:0] i2c_data_wr;
    logic [7:0]  i2c_number_of_bytes;
    logic        i2c_read_only;
    logic        i2c_busy = 1'b0;
    logic        i2c_ack_error = 1'b0;
    logic [31:0] i2c_data_rd = '0;
    logic [7:0]  i2c_byte_counter = '0;
    logic        i2c_fifo_write_ack = 1'b0;
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
    logic        irq;
    localparam logic [31:0] RD_BIT = 32'h8;
`else
    localparam logic [31:0] RD_BIT = 32'h0;
`endif

    i2c_poll_sequencer #(.NUM_SLOTS(4), .DEFAULT_PERIOD(500000), .TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .address(address), .write(write), .writedata(writedata),
        .read(read), .readdata(readdata), .waitrequest(waitrequest),
        .i2c_ena(i2c_ena), .i2c_addr(i2c_addr), .i2c_rw(i2c_rw), .i2c_data_wr(i2c_data_wr),
        .i2c_number_of_bytes(i2c_number_of_bytes), .i2c_read_only(i2c_read_only),
        .i2c_busy(i2c_busy), .i2c_ack_error(i2c_ack_error), .i2c_data_rd(i2c_data_rd),
        .i2c_byte_counter(i2c_byte_counter),
`ifdef I2C_POLL_SEQUENCER_IRQ_EN
        .irq(irq),
`endif
        .i2c_fifo_write_ack(i2c_fifo_write_ack)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] ptr;
        logic [7:0] nb;
    } xact_t;

    xact_t exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    n_unexp  = 0;
    int    cyc      = 0;
    int    hang_len = 0;
    logic [7:0] gen = 8'h00;
    logic [6:0] hang_addr = 7'h7F;
    logic [6:0] nack_addr = 7'h7F;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] resp(input logic [6:0] a);
        return (a == 7'h68) ? 32'h0000_ABCD : {gen, 16'h5A00, 1'b0, a};
    endfunction

    function automatic logic [31:0] cfg(input logic [6:0] a, input logic [7:0] p, input logic [2:0] n);
        return {13'd0, n, p, 1'b0, a};
    endfunction

    task automatic push_xact(input logic [6:0] a, input logic [7:0] p, input logic [7:0] n);
        exp_q.push_back('{addr: a, ptr: p, nb: n});
    endtask

    // i2c_master model: driven on the falling edge, away from the DUT's sampling edge.
    logic       m_active = 1'b0, m_hang = 1'b0, prev_ena = 1'b0;
    int         m_timer = 0;
    logic [7:0] m_nb = '0;
    logic [6:0] m_addr = '0;
    always @(negedge clock) begin
        if (reset) begin
            i2c_busy = 1'b0; i2c_ack_error = 1'b0; i2c_byte_counter = '0;
            i2c_fifo_write_ack = 1'b0; m_active = 1'b0; m_hang = 1'b0; prev_ena = 1'b0;
        end else begin
            if (i2c_ena && !prev_ena) begin
                if (exp_q.size() == 0) begin
                    n_unexp++;
                end else begin
                    xact_t e;
                    e = exp_q.pop_front();
                    check("xact_addr", {25'd0, i2c_addr}, {25'd0, e.addr});
                    check("xact_data_wr", i2c_data_wr, {24'd0, e.ptr});
                    check("xact_nbytes", {24'd0, i2c_number_of_bytes}, {24'd0, e.nb});
                    check("xact_rw", {31'd0, i2c_rw}, 32'd1);
                end
                m_active = 1'b1; m_timer = 0; m_nb = i2c_number_of_bytes; m_addr = i2c_addr;
                m_hang = (i2c_addr == hang_addr);
                i2c_busy = 1'b1; i2c_ack_error = 1'b0; i2c_byte_counter = '0; i2c_fifo_write_ack = 1'b0;
                if (m_hang) hang_len = 1;
            end else if (m_active) begin
                m_timer++;
                if (m_hang) begin
                    if (i2c_ena) hang_len++;
                end else begin
                    if (m_timer == 3) begin
                        i2c_data_rd = (m_addr == nack_addr) ? 32'hBAD0_0000 : resp(m_addr);
                        i2c_ack_error = (m_addr == nack_addr);
                        i2c_fifo_write_ack = 1'b1;
                    end
                    if (m_timer == 4) begin
                        i2c_fifo_write_ack = 1'b0;
                        i2c_byte_counter = m_nb;
                    end
                    if (m_timer > 4 && !i2c_ena) begin
                        i2c_busy = 1'b0;
                        m_active = 1'b0;
                    end
                end
            end
            prev_ena = i2c_ena;
        end
    end

    task automatic av_write(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        address = a; writedata = d; write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic av_read(input logic [3:0] a, output logic [31:0] d);
        @(negedge clock);
        address = a; read = 1'b1;
        #1 d = readdata;
        read = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] v;
        av_read(a, v);
        check(tag, v, exp);
    endtask

    task automatic wait_round(input logic [31:0] target, input int budget, output int at_cyc);
        logic [31:0] v = '0;
        int i = 0;
        while (i < budget) begin
            av_read(4'd12, v);
            if (v == target) break;
            i++;
        end
        at_cyc = cyc;
        if (v != target) check("wait_round_timeout", v, target);
    endtask

    task automatic wait_idle(input int budget);
        logic [31:0] v = 32'h1;
        int i = 0;
        while (i < budget && v[0]) begin
            av_read(4'd2, v);
            i++;
        end
        if (v[0]) check("wait_idle_timeout", {31'd0, v[0]}, 32'd0);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, i;
        logic [31:0] old1;

        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset state and unmapped address.
        check("rst_ena", {31'd0, i2c_ena}, 32'd0);
        check("rst_waitrequest", {31'd0, waitrequest}, 32'd0);
        check("rst_read_only", {31'd0, i2c_read_only}, 32'd0);
        rd_check("rst_ctrl", 4'd0, 32'd0);
        rd_check("rst_period", 4'd1, 32'd500000);
        rd_check("rst_status", 4'd2, 32'd0);
        rd_check("rst_slot_en", 4'd3, 32'd0);
        rd_check("rst_round", 4'd12, 32'd0);
        rd_check("unmapped", 4'd13, 32'hDEAD_BEEF);

        // Continuous polling of slot 0, period 1000.
        av_write(4'd4, cfg(7'h68, 8'h3B, 3'd2));
        av_write(4'd3, 32'h1);
        av_write(4'd1, 32'd1000);
        push_xact(7'h68, 8'h3B, 8'd2);
        push_xact(7'h68, 8'h3B, 8'd2);
        av_write(4'd0, 32'h1);
        wait_round(32'd1, 3000, t1);
        wait_round(32'd2, 3000, t2);
        av_write(4'd0, 32'h0);
        check("round_period", t2 - t1, 32'd1000);
        wait_idle(2000);
        rd_check("slot0_data", 4'd8, 32'h0000_ABCD);
        check("sb_drained_1", exp_q.size(), 32'd0);

        // Single round over SLOT_EN=1010 with nbytes boundaries 0 -> 1 and 7 -> 4.
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        av_write(4'd5, cfg(7'h11, 8'h21, 3'd0));
        av_write(4'd7, cfg(7'h33, 8'h43, 3'd7));
        av_write(4'd3, 32'hA);
        rd_check("slot1_cfg", 4'd5, cfg(7'h11, 8'h21, 3'd0));
        push_xact(7'h11, 8'h21, 8'd1);
        push_xact(7'h33, 8'h43, 8'd4);
        av_write(4'd0, 32'h2);
        wait_round(32'd1, 2000, t1);
        wait_idle(200);
        rd_check("single_ctrl", 4'd0, 32'd0);
        rd_check("single_status", 4'd2, RD_BIT);
        rd_check("slot0_untouched", 4'd8, 32'd0);
        rd_check("slot2_untouched", 4'd10, 32'd0);
        rd_check("slot1_data", 4'd9, resp(7'h11));
        rd_check("slot3_data", 4'd11, resp(7'h33));
        repeat (50) @(negedge clock);
        rd_check("single_round_once", 4'd12, 32'd1);
        check("sb_drained_2", exp_q.size(), 32'd0);

        // NACK on slot 1.
        nack_addr = 7'h11;
        old1 = resp(7'h11);
        push_xact(7'h11, 8'h21, 8'd1);
        push_xact(7'h33, 8'h43, 8'd4);
        av_write(4'd0, 32'h2);
        wait_round(32'd2, 2000, t1);
        wait_idle(200);
        rd_check("nack_status", 4'd2, 32'h102 | RD_BIT);
        rd_check("nack_slot1_kept", 4'd9, old1);
        av_write(4'd2, 32'h2);
        rd_check("ackerr_w1c", 4'd2, 32'h100 | RD_BIT);
        av_write(4'd2, 32'h1_0000);
        rd_check("errcnt_clear", 4'd2, RD_BIT);
        nack_addr = 7'h7F;

        // Slot 1 hangs: timeout, then slot 3 still serviced.
        hang_addr = 7'h11;
        gen = 8'h77;
        push_xact(7'h11, 8'h21, 8'd1);
        push_xact(7'h33, 8'h43, 8'd4);
        av_write(4'd0, 32'h2);
        wait_round(32'd3, 2000, t1);
        wait_idle(200);
        check("timeout_ena_len", hang_len, TMO);
        rd_check("timeout_status", 4'd2, 32'h104 | RD_BIT);
        rd_check("timeout_slot1_kept", 4'd9, old1);
        rd_check("timeout_next_slot", 4'd11, resp(7'h33));
        av_write(4'd2, 32'h4);
        rd_check("timeout_w1c", 4'd2, 32'h100 | RD_BIT);
        check("sb_drained_3", exp_q.size(), 32'd0);

        // Asynchronous reset while slot 1 is mid-transfer.
        push_xact(7'h11, 8'h21, 8'd1);
        av_write(4'd0, 32'h2);
        i = 0;
        while (!i2c_ena && i < 100) begin
            @(negedge clock);
            i++;
        end
        check("ena_before_reset", {31'd0, i2c_ena}, 32'd1);
        repeat (5) @(negedge clock);
        #2 reset = 1'b1;
        #1 check("reset_drops_ena", {31'd0, i2c_ena}, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        hang_addr = 7'h7F;
        rd_check("post_rst_ctrl", 4'd0, 32'd0);
        rd_check("post_rst_period", 4'd1, 32'd500000);
        rd_check("post_rst_status", 4'd2, 32'd0);
        rd_check("post_rst_slot_en", 4'd3, 32'd0);
        rd_check("post_rst_cfg1", 4'd5, 32'd0);
        rd_check("post_rst_data3", 4'd11, 32'd0);
        rd_check("post_rst_round", 4'd12, 32'd0);

`ifdef I2C_POLL_SEQUENCER_IRQ_EN
        // Interrupt on round end, cleared by writing STATUS[3].
        av_write(4'd3, 32'h1);
        push_xact(7'h00, 8'h00, 8'd1);
        av_write(4'd0, 32'h5);
        wait_round(32'd1, 2000, t1);
        check("irq_not_yet", {31'd0, irq}, 32'd0);
        @(negedge clock);
        #1 check("irq_rise", {31'd0, irq}, 32'd1);
        av_write(4'd2, 32'h8);
        #1 check("irq_held", {31'd0, irq}, 32'd1);
        @(negedge clock);
        #1 check("irq_fall", {31'd0, irq}, 32'd0);
        av_write(4'd0, 32'h0);
        wait_idle(200);
`endif

        check("sb_drained_end", exp_q.size(), 32'd0);
        check("sb_unexpected", n_unexp, 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_poll_sequencer.md
Name: i2c_poll_sequencer

Overview:
- Autonomous I2C polling engine that drives the control side of the team's i2c_master.
- Each round, walks up to NUM_SLOTS sensor slots. Per enabled slot: issues one register-pointer write plus a read of 1..4 bytes, then stores the latest 32-bit result in a shadow register.
- The HPS reads sensor data over Avalon without per-transaction software handshaking.

Parameters:
- NUM_SLOTS, 4, number of poll slots, 1..4.
- DEFAULT_PERIOD, 500000, reset value of PERIOD register, in clock cycles.
- TIMEOUT_CYCLES, 2000000, max cycles one slot transaction may take before abort.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- address  in  4  Avalon word address
- write  in  1  Avalon write strobe
- writedata  in  32  Avalon write data
- read  in  1  Avalon read strobe
- readdata  out  32  Avalon read data, combinational from address
- waitrequest  out  1  Avalon wait, tied 0
- i2c_ena  out  1  transaction enable to i2c_master
- i2c_addr  out  7  slave address
- i2c_rw  out  1  1 = pointer write then read
- i2c_data_wr  out  32  [7:0] = register pointer, rest 0
- i2c_number_of_bytes  out  8  bytes to read
- i2c_read_only  out  1  tied 0
- i2c_busy  in  1  master busy
- i2c_ack_error  in  1  master NACK flag
- i2c_data_rd  in  32  master read word
- i2c_byte_counter  in  8  bytes completed
- i2c_fifo_write_ack  in  1  level-to-edge word-ready indication from master

Behaviour:
- Register map (word addresses):
  - 0 CTRL, rw: [0] run; [1] single_round, self-clearing.
  - 1 PERIOD, rw.
  - 2 STATUS:
    - [0] fsm_active, ro.
    - [1] sticky ack_err, write 1 to clear.
    - [2] timeout, sticky, write 1 to clear.
    - [15:8] error_count, saturating at 255, cleared by writing [16]=1.
  - 3 SLOT_EN, rw, [NUM_SLOTS-1:0].
  - 4..7 SLOT_CFG, rw: [6:0] addr; [15:8] reg pointer; [18:16] nbytes.
  - 8..11 SLOT_DATA, ro.
  - 12 ROUND_COUNT, ro, 32-bit wrapping.
  - Other addresses read 32'hDEAD_BEEF. Slots >= NUM_SLOTS read 0 and ignore writes.
- Reset values:
  - All outputs 0; PERIOD = DEFAULT_PERIOD; all other registers 0; FSM in IDLE.
  - Reset mid-transaction drops i2c_ena immediately and asynchronously.
- FSM states: IDLE, WAIT_PERIOD, SELECT, START, XFER, DRAIN, STORE.
- IDLE: leave when run=1 or single_round=1.
  - Load the period counter with max(PERIOD,1).
  - Go to SELECT; the first round starts immediately.
- SELECT:
  - Scan slot index from current position upward for the next SLOT_EN bit; one slot checked per cycle.
  - No remaining enabled slot ends the round:
    - Increment ROUND_COUNT only if at least one transaction occurred.
    - Clear single_round.
    - Go to WAIT_PERIOD if run=1, else IDLE.
- START:
  - Latch the slot's CFG into the i2c_* outputs. Mid-round CFG writes affect the next visit only.
  - nbytes = 0 is treated as 1; nbytes > 4 is clamped to 4.
  - Assert i2c_ena; go to XFER.
- XFER:
  - Hold i2c_ena until i2c_byte_counter >= i2c_number_of_bytes, then deassert; go to DRAIN.
  - On a rising edge of i2c_fifo_write_ack, capture i2c_data_rd into a holding register.
- DRAIN: wait for i2c_busy = 0, then go to STORE.
- STORE:
  - If a capture occurred and there was no ack_error, write the holding register to SLOT_DATA, one cycle.
  - On ack_error: set STATUS[1], increment error_count, leave SLOT_DATA unchanged.
  - Advance slot index; go to SELECT.
- Timeout:
  - A counter runs from START. Reaching TIMEOUT_CYCLES in XFER or DRAIN forces i2c_ena = 0.
  - Sets STATUS[2] and increments error_count.
  - Goes to STORE with no data update.
- WAIT_PERIOD:
  - Period counter decrements each cycle from round start; counting overlaps the transactions.
  - At 0, or if already 0 on round end, reload and go to SELECT at slot 0.
  - run cleared while here: go to IDLE next cycle.
- Clearing run mid-round finishes the current slot, then goes to IDLE at the end of the round.
- A sticky-bit set and a software clear in the same cycle: set wins.

Optional Feature:
- Macro I2C_POLL_SEQUENCER_IRQ_EN.
- When defined:
  - Adds output irq (1 bit).
  - CTRL[2] irq_enable.
  - STATUS[3] round_done is set at every round end.
  - irq = CTRL[2] & (STATUS[3] | STATUS[1] | STATUS[2]), registered, reset 0.
  - Writing 1 to STATUS[3] clears it.
- When undefined: no irq port; CTRL[2] and STATUS[3] read 0 and ignore writes.

Test Plan:
- Slot0 cfg addr=0x68, ptr=0x3B, nbytes=2; SLOT_EN=1; PERIOD=1000; run=1; master model returns 0x0000ABCD -> i2c_ena high with i2c_addr=0x68, i2c_data_wr=0x3B, i2c_number_of_bytes=2; SLOT_DATA0=0x0000ABCD; ROUND_COUNT increments every 1000 cycles.
- SLOT_EN=4'b1010 -> per round only slots 1 then 3 are transacted, in order; slots 0 and 2 SLOT_DATA stay 0.
- Model asserts ack_error on slot 1 -> STATUS[1]=1, error_count=1, SLOT_DATA1 unchanged; write STATUS=0x2 -> STATUS[1]=0.
- Model holds i2c_busy high forever, TIMEOUT_CYCLES=100 -> i2c_ena low at 100 cycles after START, STATUS[2]=1, sequencer proceeds to the next slot.
- run=0, write CTRL=0x2 -> exactly one round, single_round reads 0 afterwards, FSM in IDLE, ROUND_COUNT +1; reset asserted mid-XFER -> i2c_ena=0 the same cycle and all registers at reset values.
- With I2C_POLL_SEQUENCER_IRQ_EN, CTRL=0x5 -> irq rises 1 cycle after round end; write STATUS=0x8 -> irq falls next cycle.
